// File: rtl/ahb_resp_mux.sv
// ahb_resp_mux: AHB-Lite slave-to-master response mux with a built-in default slave.
// Disabled slots get a two-cycle ERROR response, and those errors are counted.
module ahb_resp_mux #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] SLAVE_EN   = 4'b1111
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [1:0]            HSELx_Mux,
    input  logic [1:0]            HTRANS,
    input  logic [DATA_WIDTH-1:0] HRDATA_S0,
    input  logic [DATA_WIDTH-1:0] HRDATA_S1,
    input  logic [DATA_WIDTH-1:0] HRDATA_S2,
    input  logic [DATA_WIDTH-1:0] HRDATA_S3,
    input  logic                  HREADYOUT_S0,
    input  logic                  HREADYOUT_S1,
    input  logic                  HREADYOUT_S2,
    input  logic                  HREADYOUT_S3,
    input  logic                  HRESP_S0,
    input  logic                  HRESP_S1,
    input  logic                  HRESP_S2,
    input  logic                  HRESP_S3,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADY,
    output logic                  HRESP,
    output logic [7:0]            DEF_ERR_CNT
);
    typedef enum logic {DS_IDLE, DS_ERR2} ds_state_e;

    logic [1:0]            sel_q, sel_d;
    logic                  active_q, active_d;
    ds_state_e             state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] s_rdata;
    logic                  s_ready, s_resp, slot_en, ds_act;
    logic                  unused_htrans;

    assign unused_htrans = HTRANS[0];
    assign DEF_ERR_CNT   = cnt_q;
    assign slot_en       = SLAVE_EN[sel_q];
    assign ds_act        = active_q && !slot_en;

    // Only the registered slot is looked at, so X on unselected slaves never leaks.
    always_comb begin
        s_rdata = sel_q == 2'd0 ? HRDATA_S0 : sel_q == 2'd1 ? HRDATA_S1 :
                  sel_q == 2'd2 ? HRDATA_S2 : HRDATA_S3;
        s_ready = sel_q == 2'd0 ? HREADYOUT_S0 : sel_q == 2'd1 ? HREADYOUT_S1 :
                  sel_q == 2'd2 ? HREADYOUT_S2 : HREADYOUT_S3;
        s_resp  = sel_q == 2'd0 ? HRESP_S0 : sel_q == 2'd1 ? HRESP_S1 :
                  sel_q == 2'd2 ? HRESP_S2 : HRESP_S3;
    end

    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        if (active_q && slot_en) begin
            HRDATA = s_rdata;
            HREADY = s_ready;
            HRESP  = s_resp;
        end else if (ds_act) begin
            HREADY = state_q == DS_ERR2;
            HRESP  = 1'b1;
        end
    end

    always_comb begin
        sel_d    = HREADY ? HSELx_Mux : sel_q;
        active_d = HREADY ? HTRANS[1] : active_q;
        state_d  = (ds_act && state_q == DS_IDLE) ? DS_ERR2 : DS_IDLE;
        cnt_d    = (ds_act && state_q == DS_ERR2 && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q    <= 2'd0;
            active_q <= 1'b0;
            state_q  <= DS_IDLE;
            cnt_q    <= 8'd0;
        end else begin
            sel_q    <= sel_d;
            active_q <= active_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ahb_resp_mux.sv
// tb_ahb_resp_mux: directed bench; dut_a has all slots enabled, dut_b has slot 1 disabled.
module tb_ahb_resp_mux;
    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [1:0]  HSELx_Mux, HTRANS;
    logic [31:0] HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3;
    logic        HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3;
    logic        HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3;
    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b, resp_a, resp_b;
    logic [7:0]  cnt_a, cnt_b;
    int          checks = 0;
    int          errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_resp_mux #(.DATA_WIDTH(32), .SLAVE_EN(4'b1111)) dut_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELx_Mux(HSELx_Mux), .HTRANS(HTRANS),
        .HRDATA_S0(HRDATA_S0), .HRDATA_S1(HRDATA_S1), .HRDATA_S2(HRDATA_S2), .HRDATA_S3(HRDATA_S3),
        .HREADYOUT_S0(HREADYOUT_S0), .HREADYOUT_S1(HREADYOUT_S1),
        .HREADYOUT_S2(HREADYOUT_S2), .HREADYOUT_S3(HREADYOUT_S3),
        .HRESP_S0(HRESP_S0), .HRESP_S1(HRESP_S1), .HRESP_S2(HRESP_S2), .HRESP_S3(HRESP_S3),
        .HRDATA(rdata_a), .HREADY(ready_a), .HRESP(resp_a), .DEF_ERR_CNT(cnt_a)
    );

    ahb_resp_mux #(.DATA_WIDTH(32), .SLAVE_EN(4'b1101)) dut_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELx_Mux(HSELx_Mux), .HTRANS(HTRANS),
        .HRDATA_S0(HRDATA_S0), .HRDATA_S1(HRDATA_S1), .HRDATA_S2(HRDATA_S2), .HRDATA_S3(HRDATA_S3),
        .HREADYOUT_S0(HREADYOUT_S0), .HREADYOUT_S1(HREADYOUT_S1),
        .HREADYOUT_S2(HREADYOUT_S2), .HREADYOUT_S3(HREADYOUT_S3),
        .HRESP_S0(HRESP_S0), .HRESP_S1(HRESP_S1), .HRESP_S2(HRESP_S2), .HRESP_S3(HRESP_S3),
        .HRDATA(rdata_b), .HREADY(ready_b), .HRESP(resp_b), .DEF_ERR_CNT(cnt_b)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic pulse_reset();
        HRESETn = 1'b0;
        HTRANS  = 2'b00;
        cyc();
        HRESETn = 1'b1;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        HTRANS = 2'b10;
        HSELx_Mux = 2'd1;
        #1;
        if (ready_b !== 1'b1 || resp_b !== 1'b0 || rdata_b !== 32'h0 || cnt_b !== 8'd0) begin
            errors++;
            $display("FAIL reset_assert: ready=%b resp=%b rdata=%h cnt=%0d, want 1 0 0 0", ready_b, resp_b, rdata_b, cnt_b);
        end
        checks++;
        cyc();
        cyc();
        HRESETn = 1'b1;
        HTRANS = 2'b00;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (ready_a !== 1'b1 || resp_a !== 1'b0 || rdata_a !== 32'h0 || cnt_a !== 8'd0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: ready=%b resp=%b rdata=%h cnt=%0d, want 1 0 0 0", i, ready_a, resp_a, rdata_a, cnt_a);
            end
            checks++;
        end
    endtask

    task automatic test_zero_wait();
        HRDATA_S2 = 32'hA5A5_0002; HREADYOUT_S2 = 1'b1; HRESP_S2 = 1'b0;
        HRDATA_S1 = 32'h1111_0001; HREADYOUT_S1 = 1'b1; HRESP_S1 = 1'b0;
        HREADYOUT_S0 = 1'bx; HRESP_S0 = 1'bx;
        HSELx_Mux = 2'd2; HTRANS = 2'b10;
        cyc();
        HSELx_Mux = 2'd1; HTRANS = 2'b10;
        #1;
        if (rdata_a !== 32'hA5A5_0002 || ready_a !== 1'b1 || resp_a !== 1'b0) begin
            errors++;
            $display("FAIL zero_wait_s2: rdata=%h ready=%b resp=%b, want a5a50002 1 0", rdata_a, ready_a, resp_a);
        end
        checks++;
        cyc();
        HTRANS = 2'b00;
        #1;
        if (rdata_a !== 32'h1111_0001 || ready_a !== 1'b1 || resp_a !== 1'b0) begin
            errors++;
            $display("FAIL pipelined_s1: rdata=%h ready=%b resp=%b, want 11110001 1 0", rdata_a, ready_a, resp_a);
        end
        checks++;
        cyc();
        if (rdata_a !== 32'h0 || ready_a !== 1'b1) begin
            errors++;
            $display("FAIL after_idle: rdata=%h ready=%b, want 0 1", rdata_a, ready_a);
        end
        checks++;
        HREADYOUT_S0 = 1'b1; HRESP_S0 = 1'b0;
    endtask

    task automatic test_wait_states();
        HRDATA_S0 = 32'h0F0F_0000; HREADYOUT_S0 = 1'b1;
        HRDATA_S3 = 32'hC3C3_0003; HREADYOUT_S3 = 1'b0; HRESP_S3 = 1'b0;
        HSELx_Mux = 2'd3; HTRANS = 2'b10;
        cyc();
        for (int i = 0; i < 3; i++) begin
            HSELx_Mux = 2'd0;
            #1;
            if (ready_a !== 1'b0 || rdata_a !== 32'hC3C3_0003) begin
                errors++;
                $display("FAIL wait_s3[%0d]: ready=%b rdata=%h, want 0 c3c30003", i, ready_a, rdata_a);
            end
            checks++;
            cyc();
        end
        HREADYOUT_S3 = 1'b1;
        #1;
        if (ready_a !== 1'b1 || rdata_a !== 32'hC3C3_0003 || resp_a !== 1'b0) begin
            errors++;
            $display("FAIL wait_done_s3: ready=%b rdata=%h resp=%b, want 1 c3c30003 0", ready_a, rdata_a, resp_a);
        end
        checks++;
        cyc();
        HTRANS = 2'b00;
        #1;
        if (rdata_a !== 32'h0F0F_0000 || ready_a !== 1'b1) begin
            errors++;
            $display("FAIL after_wait_s0: rdata=%h ready=%b, want 0f0f0000 1", rdata_a, ready_a);
        end
        checks++;
        cyc();
    endtask

    task automatic test_disabled();
        pulse_reset();
        HSELx_Mux = 2'd1; HTRANS = 2'b10;
        cyc();
        HTRANS = 2'b00;
        #1;
        if (ready_b !== 1'b0 || resp_b !== 1'b1 || rdata_b !== 32'h0) begin
            errors++;
            $display("FAIL ds_err1: ready=%b resp=%b rdata=%h, want 0 1 0", ready_b, resp_b, rdata_b);
        end
        checks++;
        cyc();
        if (ready_b !== 1'b1 || resp_b !== 1'b1 || cnt_b !== 8'd0) begin
            errors++;
            $display("FAIL ds_err2: ready=%b resp=%b cnt=%0d, want 1 1 0", ready_b, resp_b, cnt_b);
        end
        checks++;
        cyc();
        if (ready_b !== 1'b1 || resp_b !== 1'b0 || cnt_b !== 8'd1) begin
            errors++;
            $display("FAIL ds_done: ready=%b resp=%b cnt=%0d, want 1 0 1", ready_b, resp_b, cnt_b);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        HSELx_Mux = 2'd1; HTRANS = 2'b10;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (i == 6) HTRANS = 2'b00;
            #1;
            if (resp_b !== 1'b1 || ready_b !== (i % 2 == 0)) begin
                errors++;
                $display("FAIL b2b[%0d]: ready=%b resp=%b, want %b 1", i, ready_b, resp_b, (i % 2 == 0));
            end
            checks++;
        end
        cyc();
        if (cnt_b !== 8'd3 || resp_b !== 1'b0) begin
            errors++;
            $display("FAIL b2b_cnt: cnt=%0d resp=%b, want 3 0", cnt_b, resp_b);
        end
        checks++;
    endtask

    task automatic test_saturation();
        pulse_reset();
        HSELx_Mux = 2'd1; HTRANS = 2'b10;
        for (int i = 1; i <= 520; i++) begin
            cyc();
            if (i == 520) HTRANS = 2'b00;
            if (i == 201) begin
                if (cnt_b !== 8'd100) begin
                    errors++;
                    $display("FAIL sat_mid: cnt=%0d, want 100", cnt_b);
                end
                checks++;
            end
        end
        cyc();
        cyc();
        if (cnt_b !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold: cnt=%0d, want 255", cnt_b);
        end
        checks++;
    endtask

    task automatic test_reset_mid_error();
        HSELx_Mux = 2'd1; HTRANS = 2'b10;
        cyc();
        HTRANS = 2'b00;
        cyc();
        HRESETn = 1'b0;
        #1;
        if (ready_b !== 1'b1 || resp_b !== 1'b0 || cnt_b !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_err: ready=%b resp=%b cnt=%0d, want 1 0 0", ready_b, resp_b, cnt_b);
        end
        checks++;
        cyc();
        HRESETn = 1'b1;
        HTRANS = 2'b10;
        cyc();
        HTRANS = 2'b00;
        #1;
        if (ready_b !== 1'b0 || resp_b !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_err1: ready=%b resp=%b, want 0 1", ready_b, resp_b);
        end
        checks++;
        cyc();
        if (ready_b !== 1'b1 || resp_b !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_err2: ready=%b resp=%b, want 1 1", ready_b, resp_b);
        end
        checks++;
        cyc();
        if (cnt_b !== 8'd1) begin
            errors++;
            $display("FAIL post_reset_cnt: cnt=%0d, want 1", cnt_b);
        end
        checks++;
    endtask

    initial begin
        HRESETn = 1'b0; HSELx_Mux = 2'd0; HTRANS = 2'b00;
        HRDATA_S0 = '0; HRDATA_S1 = '0; HRDATA_S2 = '0; HRDATA_S3 = '0;
        HREADYOUT_S0 = 1'b1; HREADYOUT_S1 = 1'b1; HREADYOUT_S2 = 1'b1; HREADYOUT_S3 = 1'b1;
        HRESP_S0 = 1'b0; HRESP_S1 = 1'b0; HRESP_S2 = 1'b0; HRESP_S3 = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_disabled();
        test_back_to_back();
        test_saturation();
        test_reset_mid_error();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
